voter_tally: RTL and testbench

- Clocked, parametrised successor to the combinational 4-input voter.
- Runs voting sessions for N_VOTERS voters. Each voter may cast at most one yes/no ballot per session.
- Keeps running yes/no tallies, closes the session on request, when all voters have voted, or on timeout, then presents a held pass/fail/tie verdict until acknowledged.
- Sits between the per-voter input synchronisers and the result display/logging logic.

---
 rtl/voter_pkg.sv | 30 +++
 rtl/voter_popcount.sv | 21 ++
 rtl/voter_tally.sv | 203 ++++++++++++++++++++
 tb/tb_voter_tally.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/voter_pkg.sv
// voter_pkg: types and constants shared by the voter_tally block.
// The quorum check is built only when VOTER_QUORUM_EN is defined.
package voter_pkg;

  // Session phases of the tally FSM.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPEN   = 2'd1,
    DECIDE = 2'd2,
    RESULT = 2'd3
  } state_t;

  // Verdict bits ordered {pass, fail, tie}, matching the legacy 3-bit voter output.
  localparam int         VERDICT_W    = 3;
  localparam logic [2:0] VERDICT_PASS = 3'b100;
  localparam logic [2:0] VERDICT_FAIL = 3'b010;
  localparam logic [2:0] VERDICT_TIE  = 3'b001;
  localparam logic [2:0] VERDICT_NONE = 3'b000;

  // Bits needed to hold the values 0..n. Returns clog2(n+1), never less than 1.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) <= n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/voter_popcount.sv
// voter_popcount: combinational population count of a W-bit vector.
// The result width defaults to just enough bits to hold W.
module voter_popcount
  import voter_pkg::*;
#(
  parameter int W  = 4,
  parameter int CW = cnt_width(W)
) (
  input  logic [W-1:0]  vec,
  output logic [CW-1:0] count
);

  // Sum the individual bits; a simple adder chain is plenty for up to 32 inputs.
  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/voter_tally.sv
// voter_tally: clocked voting session controller for N_VOTERS channels.
// Opens a session on start, accepts at most one ballot per voter, closes on
// request / all voted / timeout, then holds a pass/fail/tie verdict until
// acknowledged. Optional quorum check: define VOTER_QUORUM_EN.
//
// Verdict handshake: result_valid rises with the verdict flags and holds them
// unchanged until a rising edge sees result_valid && result_ack; on that edge
// the transfer completes and result_valid plus all flags drop. result_ack with
// result_valid low has no effect, and result_valid never drops without an ack.
module voter_tally
  import voter_pkg::*;
#(
  parameter  int N_VOTERS       = 4,
  parameter  int TIMEOUT_CYCLES = 64,
  parameter  int QUORUM         = 3,
  localparam int CNT_W          = cnt_width(N_VOTERS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                close,
  input  logic [N_VOTERS-1:0] vote_valid,
  input  logic [N_VOTERS-1:0] vote_yes,
  input  logic                result_ack,
  output logic                busy,
  output logic [N_VOTERS-1:0] voted,
  output logic [CNT_W-1:0]    yes_count,
  output logic [CNT_W-1:0]    no_count,
  output logic                result_valid,
  output logic                result_pass,
  output logic                result_fail,
  output logic                result_tie,
  output logic                result_noq,
  output state_t              state_dbg
);

  // Timer only needs to reach TIMEOUT_CYCLES-1; with the timeout disabled it
  // simply free-runs inside OPEN and is never compared.
  localparam int               TMR_W    = cnt_width(TIMEOUT_CYCLES);
  localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [TMR_W-1:0] TMR_LAST =
    TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  // Elaboration-time guards on the configuration.
  if (N_VOTERS < 2 || N_VOTERS > 32) begin : g_bad_voters
    $error("voter_tally: N_VOTERS must lie in 2..32");
  end
  if (QUORUM < 0 || TIMEOUT_CYCLES < 0) begin : g_bad_cfg
    $error("voter_tally: QUORUM and TIMEOUT_CYCLES must be non-negative");
  end

  state_t              state_q, state_d;
  logic [N_VOTERS-1:0] voted_q, voted_d;
  logic [CNT_W-1:0]    yes_q, yes_d;
  logic [CNT_W-1:0]    no_q, no_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                valid_q, valid_d;
  logic [2:0]          verdict_q, verdict_d;
  logic                noq_q, noq_d;

  logic [N_VOTERS-1:0] new_w;
  logic [N_VOTERS-1:0] yes_bal_w;
  logic [N_VOTERS-1:0] no_bal_w;
  logic [CNT_W-1:0]    yes_add_w;
  logic [CNT_W-1:0]    no_add_w;
  logic                all_voted_w;
  logic                timeout_w;
  logic                close_now_w;

  // First-time ballots only; nothing is captured outside OPEN.
  always_comb begin
    new_w       = (state_q == OPEN) ? (vote_valid & ~voted_q) : '0;
    yes_bal_w   = new_w & vote_yes;
    no_bal_w    = new_w & ~vote_yes;
    all_voted_w = &(voted_q | new_w);
    timeout_w   = TO_EN && (timer_q == TMR_LAST);
    close_now_w = (state_q == OPEN) && (close || all_voted_w || timeout_w);
  end

  voter_popcount #(.W(N_VOTERS), .CW(CNT_W)) u_pop_yes (
    .vec   (yes_bal_w),
    .count (yes_add_w)
  );

  voter_popcount #(.W(N_VOTERS), .CW(CNT_W)) u_pop_no (
    .vec   (no_bal_w),
    .count (no_add_w)
  );

  // State and datapath registers; reset aborts any session with no verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      voted_q   <= '0;
      yes_q     <= '0;
      no_q      <= '0;
      timer_q   <= '0;
      valid_q   <= 1'b0;
      verdict_q <= VERDICT_NONE;
      noq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      voted_q   <= voted_d;
      yes_q     <= yes_d;
      no_q      <= no_d;
      timer_q   <= timer_d;
      valid_q   <= valid_d;
      verdict_q <= verdict_d;
      noq_q     <= noq_d;
    end
  end

  // Next-state logic for the session FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = OPEN;
      OPEN:    if (close_now_w) state_d = DECIDE;
      DECIDE:  state_d = RESULT;
      RESULT:  if (result_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tally, timer and verdict updates for each state.
  always_comb begin
    voted_d   = voted_q;
    yes_d     = yes_q;
    no_d      = no_q;
    timer_d   = timer_q;
    valid_d   = valid_q;
    verdict_d = verdict_q;
    noq_d     = noq_q;
    case (state_q)
      IDLE: begin
        // Previous counts stay visible until the next session starts.
        if (start) begin
          voted_d = '0;
          yes_d   = '0;
          no_d    = '0;
          timer_d = '0;
        end
      end
      OPEN: begin
        voted_d = voted_q | new_w;
        yes_d   = yes_q + yes_add_w;
        no_d    = no_q + no_add_w;
        timer_d = timer_q + TMR_W'(1);
      end
      DECIDE: begin
        valid_d = 1'b1;
        noq_d   = 1'b0;
        if (yes_q > no_q) begin
          verdict_d = VERDICT_PASS;
        end else if (no_q > yes_q) begin
          verdict_d = VERDICT_FAIL;
        end else begin
          verdict_d = VERDICT_TIE;
        end
`ifdef VOTER_QUORUM_EN
        // Too few ballots: no verdict, only the no-quorum flag.
        if ((int'(yes_q) + int'(no_q)) < QUORUM) begin
          verdict_d = VERDICT_NONE;
          noq_d     = 1'b1;
        end
`endif
      end
      RESULT: begin
        if (result_ack) begin
          valid_d   = 1'b0;
          verdict_d = VERDICT_NONE;
          noq_d     = 1'b0;
        end
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  // Output mapping straight from the registers.
  assign busy         = (state_q == OPEN) || (state_q == DECIDE);
  assign voted        = voted_q;
  assign yes_count    = yes_q;
  assign no_count     = no_q;
  assign result_valid = valid_q;
  assign result_pass  = verdict_q[2];
  assign result_fail  = verdict_q[1];
  assign result_tie   = verdict_q[0];
  assign state_dbg    = state_q;
`ifdef VOTER_QUORUM_EN
  assign result_noq   = noq_q;
`else
  assign result_noq   = 1'b0;
`endif

`ifndef VOTER_QUORUM_EN
  // Without the quorum feature the no-quorum register never leaves zero.
  logic unused_noq;
  assign unused_noq = noq_q;
`endif

endmodule

// File: tb/tb_voter_tally.sv
// tb_voter_tally: scenario bench for voter_tally (N_VOTERS=4, TIMEOUT_CYCLES=8,
// QUORUM=3). Build with or without VOTER_QUORUM_EN.
`timescale 1ns/1ps
module tb_voter_tally;
  import voter_pkg::*;

  localparam int N  = 4;
  localparam int TO = 8;
  localparam int Q  = 3;
  localparam int CW = 3;
  localparam int W  = 4 + CW + CW + N;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         close = 1'b0;
  logic         result_ack = 1'b0;
  logic [N-1:0] vote_valid = '0;
  logic [N-1:0] vote_yes = '0;

  logic          busy;
  logic [N-1:0]  voted;
  logic [CW-1:0] yes_count;
  logic [CW-1:0] no_count;
  logic          result_valid;
  logic          result_pass;
  logic          result_fail;
  logic          result_tie;
  logic          result_noq;
  state_t        state_dbg;

  always #5 clk = ~clk;

  voter_tally #(.N_VOTERS(N), .TIMEOUT_CYCLES(TO), .QUORUM(Q)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .close        (close),
    .vote_valid   (vote_valid),
    .vote_yes     (vote_yes),
    .result_ack   (result_ack),
    .busy         (busy),
    .voted        (voted),
    .yes_count    (yes_count),
    .no_count     (no_count),
    .result_valid (result_valid),
    .result_pass  (result_pass),
    .result_fail  (result_fail),
    .result_tie   (result_tie),
    .result_noq   (result_noq),
    .state_dbg    (state_dbg)
  );

  // ---------------- scoreboard ----------------
  // Record layout: {noq, pass, fail, tie, yes, no, voted}
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  last_exp;
  int            n_cmp = 0;
  int            n_fail = 0;

  // Reference session model kept by the bench.
  logic [N-1:0]  m_voted;
  logic [CW-1:0] m_yes;
  logic [CW-1:0] m_no;
  int            m_timer;

  function automatic logic [W-1:0] obs();
    return {result_noq, result_pass, result_fail, result_tie, yes_count, no_count, voted};
  endfunction

  function automatic logic [W-1:0] make_exp();
    logic p, f, t, q;
    p = (m_yes > m_no);
    f = (m_no > m_yes);
    t = (m_yes == m_no);
    q = 1'b0;
`ifdef VOTER_QUORUM_EN
    if ((int'(m_yes) + int'(m_no)) < Q) begin
      q = 1'b1; p = 1'b0; f = 1'b0; t = 1'b0;
    end
`endif
    return {q, p, f, t, m_yes, m_no, m_voted};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    m_voted = '0;
    m_yes   = '0;
    m_no    = '0;
    m_timer = 0;
  endtask

  // One OPEN cycle of stimulus; pushes the expected verdict if it closes.
  task automatic open_cycle(input logic [N-1:0] v, input logic [N-1:0] y, input logic cl);
    logic [N-1:0] nw;
    logic         closing;
    nw      = v & ~m_voted;
    m_voted = m_voted | nw;
    m_yes   = m_yes + CW'($countones(nw & y));
    m_no    = m_no + CW'($countones(nw & ~y));
    closing = cl || (m_voted == {N{1'b1}}) || (m_timer == TO - 1);
    m_timer = m_timer + 1;
    if (closing) exp_q.push_back(make_exp());
    vote_valid = v;
    vote_yes   = y;
    close      = cl;
    @(negedge clk);
    vote_valid = '0;
    vote_yes   = '0;
    close      = 1'b0;
  endtask

  // Called at the negedge right after the closing edge; verdict due 2 edges later.
  task automatic wait_result(input string name);
    int lat;
    lat = 1;
    while (!result_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (!result_valid) begin
      n_fail++;
      $display("FAIL %s_valid: result_valid=0 after %0d cycles, required 1", name, lat);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      n_cmp++;
      if (lat != 2) begin
        n_fail++;
        $display("FAIL %s_latency: got %0d cycles, required 2", name, lat);
      end
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s_verdict: got %h with no expected entry, required none", name, obs());
      end else begin
        last_exp = exp_q.pop_front();
        if (obs() !== last_exp) begin
          n_fail++;
          $display("FAIL %s_verdict: got %h, required %h", name, obs(), last_exp);
        end
      end
    end
  endtask

  task automatic do_ack(input string name);
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    n_cmp++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL %s_ack: valid=%b busy=%b state=%0d, required 0 0 %0d",
               name, result_valid, busy, state_dbg, IDLE);
    end
    n_cmp++;
    if (obs() !== {4'b0000, m_yes, m_no, m_voted}) begin
      n_fail++;
      $display("FAIL %s_ack_counts: got %h, required %h", name, obs(), {4'b0000, m_yes, m_no, m_voted});
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2;
    n_cmp++;
    if (obs() !== W'(0) || busy !== 1'b0 || result_valid !== 1'b0 || state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL reset: out=%h busy=%b valid=%b state=%0d, required 0 0 0 0",
               obs(), busy, result_valid, state_dbg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (state_dbg !== IDLE || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: state=%0d busy=%b, required %0d 0", state_dbg, busy, IDLE);
    end
  endtask

  task automatic test_unanimous();
    do_start();
    n_cmp++;
    if (busy !== 1'b1 || state_dbg !== OPEN) begin
      n_fail++;
      $display("FAIL unan_open: busy=%b state=%0d, required 1 %0d", busy, state_dbg, OPEN);
    end
    open_cycle(4'b1111, 4'b1111, 1'b0);
    wait_result("unanimous");
    do_ack("unanimous");
  endtask

  task automatic test_split_dup();
    do_start();
    open_cycle(4'b0001, 4'b0001, 1'b0);
    open_cycle(4'b0010, 4'b0000, 1'b0);
    open_cycle(4'b0001, 4'b0000, 1'b0);
    n_cmp++;
    if (yes_count !== CW'(1) || no_count !== CW'(1) || voted !== 4'b0011) begin
      n_fail++;
      $display("FAIL split_dup: yes=%0d no=%0d voted=%b, required 1 1 0011", yes_count, no_count, voted);
    end
    open_cycle(4'b1100, 4'b0000, 1'b0);
    wait_result("split");
    do_ack("split");
  endtask

  task automatic test_early_close();
    do_start();
    open_cycle(4'b0001, 4'b0001, 1'b0);
    open_cycle(4'b0100, 4'b0000, 1'b0);
    open_cycle(4'b0000, 4'b0000, 1'b1);
    wait_result("early_close");
    do_ack("early_close");
  endtask

  task automatic test_timeout();
    do_start();
    for (int i = 0; i < TO - 1; i++) open_cycle('0, '0, 1'b0);
    n_cmp++;
    if (state_dbg !== OPEN) begin
      n_fail++;
      $display("FAIL timeout_early: state=%0d after %0d cycles, required %0d", state_dbg, TO - 1, OPEN);
    end
    open_cycle('0, '0, 1'b0);
    wait_result("timeout");
    for (int i = 0; i < 2; i++) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (state_dbg !== RESULT || result_valid !== 1'b1 || obs() !== last_exp) begin
        n_fail++;
        $display("FAIL timeout_start_ignored: state=%0d valid=%b out=%h, required %0d 1 %h",
                 state_dbg, result_valid, obs(), RESULT, last_exp);
      end
    end
    do_ack("timeout");
  endtask

  task automatic test_ignored_idle();
    vote_valid = 4'b1111;
    vote_yes   = 4'b1010;
    close      = 1'b1;
    result_ack = 1'b1;
    @(negedge clk);
    vote_valid = '0;
    vote_yes   = '0;
    close      = 1'b0;
    result_ack = 1'b0;
    n_cmp++;
    if (state_dbg !== IDLE || obs() !== {4'b0000, m_yes, m_no, m_voted} || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ignore: state=%0d out=%h valid=%b, required %0d %h 0",
               state_dbg, obs(), result_valid, IDLE, {4'b0000, m_yes, m_no, m_voted});
    end
  endtask

  task automatic test_reset_mid();
    do_start();
    open_cycle(4'b0011, 4'b0011, 1'b0);
    n_cmp++;
    if (yes_count !== CW'(2)) begin
      n_fail++;
      $display("FAIL mid_yes: got %0d, required 2", yes_count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== W'(0) || busy !== 1'b0 || result_valid !== 1'b0 || state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL mid_reset: out=%h busy=%b valid=%b state=%0d, required 0 0 0 0",
               obs(), busy, result_valid, state_dbg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (state_dbg !== IDLE || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_release: state=%0d busy=%b, required %0d 0", state_dbg, busy, IDLE);
    end
    do_start();
    open_cycle(4'b1111, 4'b0000, 1'b0);
    wait_result("after_reset");
    do_ack("after_reset");
  endtask

  task automatic test_hold_ack();
    do_start();
    open_cycle(4'b0111, 4'b0110, 1'b0);
    open_cycle(4'b1000, 4'b1000, 1'b0);
    wait_result("hold");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (result_valid !== 1'b1 || state_dbg !== RESULT || obs() !== last_exp) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: valid=%b state=%0d out=%h, required 1 %0d %h",
                 i, result_valid, state_dbg, obs(), RESULT, last_exp);
      end
    end
    do_ack("hold");
  endtask

  task automatic test_back_to_back();
    do_start();
    open_cycle(4'b1111, 4'b0101, 1'b0);
    wait_result("b2b_first");
    start      = 1'b1;
    result_ack = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    result_ack = 1'b0;
    n_cmp++;
    if (state_dbg !== IDLE || result_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_start_ack: state=%0d valid=%b busy=%b, required %0d 0 0",
               state_dbg, result_valid, busy, IDLE);
    end
    do_start();
    open_cycle(4'b0110, 4'b0100, 1'b0);
    open_cycle(4'b1001, 4'b1001, 1'b0);
    wait_result("b2b_second");
    do_ack("b2b_second");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_unanimous();
    test_split_dup();
    test_early_close();
    test_ignored_idle();
    test_timeout();
    test_reset_mid();
    test_hold_ack();
    test_back_to_back();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: %0d expected verdicts never seen, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
